// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid boot checker: FSM state encoding,
// sysid slave word addresses and the supported read-latency ceiling.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_RD_TS,
    ST_WAIT_TS,
    ST_CHECK
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID     = 1'b0;
  localparam logic SYSID_ADDR_TS     = 1'b1;
  localparam int   SYSID_MAX_LATENCY = 4;

endpackage

// File: rtl/sysid_rd_delay.sv
// Read-valid delay line: turns the one-cycle read strobe into a capture strobe
// LATENCY cycles later, matching the fixed slave read latency.
module sysid_rd_delay
  import sysid_check_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rd_i,
  output logic stb_o
);

  logic [LATENCY-1:0] vld_pipe_q;

  // Truncating cast drops the oldest bit, giving a plain shift toward the MSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_pipe_q <= '0;
    else          vld_pipe_q <= LATENCY'({vld_pipe_q, rd_i});
  end

  assign stb_o = vld_pipe_q[LATENCY-1];

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and flags
// whether they match the build-time values. Define SYSID_CHECK_RETRY_EN to retry failed checks.
module sysid_boot_checker
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h1111_1111,
  parameter logic [31:0] EXPECTED_TS  = 32'h5303_7B79,
  parameter int          READ_LATENCY = 1,
  parameter bit          AUTO_START   = 1'b1,
  parameter int          MAX_RETRIES  = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state_q;
  logic         rd_q, addr_q, busy_q, done_q, id_ok_q, ts_ok_q, auto_pend_q;
  logic [31:0]  id_q, ts_q;
  logic         cap_stb;
  logic         id_ok_d, ts_ok_d;
`ifdef SYSID_CHECK_RETRY_EN
  logic [3:0]   retry_q;
  logic         retry_d;
`else
  logic         unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRIES != 0);
`endif

  sysid_rd_delay #(.LATENCY(READ_LATENCY)) u_rd_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_i    (rd_q),
    .stb_o   (cap_stb)
  );

  // Timestamp compares against the live bus so flags and done land together in CHECK.
  assign id_ok_d = (id_q == EXPECTED_ID);
  assign ts_ok_d = (avm_readdata == EXPECTED_TS);
`ifdef SYSID_CHECK_RETRY_EN
  assign retry_d = !(id_ok_d && ts_ok_d) && (retry_q < 4'(MAX_RETRIES));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      addr_q      <= SYSID_ADDR_ID;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      id_q        <= '0;
      ts_q        <= '0;
      auto_pend_q <= AUTO_START;
`ifdef SYSID_CHECK_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start || auto_pend_q) begin
          auto_pend_q <= 1'b0;
          busy_q      <= 1'b1;
          rd_q        <= 1'b1;
          addr_q      <= SYSID_ADDR_ID;
          state_q     <= ST_RD_ID;
`ifdef SYSID_CHECK_RETRY_EN
          retry_q     <= '0;
`endif
        end
        ST_RD_ID: state_q <= ST_WAIT_ID;
        ST_WAIT_ID: if (cap_stb) begin
          id_q    <= avm_readdata;
          rd_q    <= 1'b1;
          addr_q  <= SYSID_ADDR_TS;
          state_q <= ST_RD_TS;
        end
        ST_RD_TS: state_q <= ST_WAIT_TS;
        ST_WAIT_TS: if (cap_stb) begin
          ts_q    <= avm_readdata;
          id_ok_q <= id_ok_d;
          ts_ok_q <= ts_ok_d;
          state_q <= ST_CHECK;
`ifdef SYSID_CHECK_RETRY_EN
          done_q  <= !retry_d;
`else
          done_q  <= 1'b1;
`endif
        end
        ST_CHECK: begin
`ifdef SYSID_CHECK_RETRY_EN
          if (!(id_ok_q && ts_ok_q) && (retry_q < 4'(MAX_RETRIES))) begin
            retry_q <= retry_q + 4'd1;
            rd_q    <= 1'b1;
            addr_q  <= SYSID_ADDR_ID;
            state_q <= ST_RD_ID;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker with a latency-1 sysid slave model.
module tb_sysid_boot_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok;
  logic [31:0] avm_readdata = 32'hDEAD_BEEF;
  logic [31:0] id_value, ts_value;
  logic [31:0] id_ret = 32'h1111_1111;
  logic [31:0] ts_ret = 32'h5303_7B79;
  int ncmp = 0, nfail = 0;
  int nreads = 0, ndone = 0;

  always #5 clock = ~clock;

  sysid_boot_checker #(
    .EXPECTED_ID(32'h1111_1111), .EXPECTED_TS(32'h5303_7B79),
    .READ_LATENCY(1), .AUTO_START(1'b1), .MAX_RETRIES(3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .id_value(id_value), .ts_value(ts_value)
  );

  // Latency-1 slave; returns junk when not addressed so late/early captures show up.
  always @(posedge clock) begin
    avm_readdata <= avm_read ? (avm_address ? ts_ret : id_ret) : 32'hDEAD_BEEF;
    if (avm_read) nreads <= nreads + 1;
    if (done)     ndone  <= ndone + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start, then records outputs at cycles 1..7 (bit index = cycle).
  task automatic run_start(input int restart_cyc, output logic [7:0] rd, output logic [7:0] bsy,
                           output logic [7:0] dn, output logic [1:0] ok4);
    rd = '0; bsy = '0; dn = '0; ok4 = '0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clock);
      rd[c] = avm_read; bsy[c] = busy; dn[c] = done;
      if (c == 4) ok4 = {id_ok, ts_ok};
      start = (c == restart_cyc);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] rd, bsy, dn;
    logic [1:0] ok4;
    logic [7:0] dn_auto;
    int r0, d0, wait_cyc;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_read", {31'b0, avm_read}, 32'd0);
    chk("rst_addr", {31'b0, avm_address}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_flags", {29'b0, done, id_ok, ts_ok}, 32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", ts_value, 32'd0);

    // Auto-start after release: done in cycle 5 only
    reset_n = 1'b1;
    dn_auto = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      dn_auto[c] = done;
      if (c == 5) chk("auto_ok", {30'b0, id_ok, ts_ok}, 32'd3);
    end
    chk("auto_done", {24'b0, dn_auto}, 32'h20);

    // Good check from start
    run_start(0, rd, bsy, dn, ok4);
    chk("good_read", {24'b0, rd}, 32'h0A);
    chk("good_busy", {24'b0, bsy}, 32'h3E);
    chk("good_done", {24'b0, dn}, 32'h20);
    chk("good_ok", {30'b0, id_ok, ts_ok}, 32'd3);
    chk("good_id", id_value, 32'h1111_1111);
    chk("good_ts", ts_value, 32'h5303_7B79);

    // Bad timestamp
    ts_ret = 32'h0;
    run_start(0, rd, bsy, dn, ok4);
    chk("badts_done", {24'b0, dn}, 32'h20);
    chk("badts_hold", {30'b0, ok4}, 32'd3);
    chk("badts_ok", {30'b0, id_ok, ts_ok}, 32'd2);
    chk("badts_ts", ts_value, 32'h0);

    // start while busy is ignored; flags hold until CHECK
    ts_ret = 32'h5303_7B79;
    r0 = nreads; d0 = ndone;
    run_start(2, rd, bsy, dn, ok4);
    chk("busy_read", {24'b0, rd}, 32'h0A);
    chk("busy_done", {24'b0, dn}, 32'h20);
    chk("busy_hold", {30'b0, ok4}, 32'd2);
    chk("busy_nreads", nreads - r0, 32'd2);
    chk("busy_ndone", ndone - d0, 32'd1);
    chk("busy_ok", {30'b0, id_ok, ts_ok}, 32'd3);

    // Reset in cycle 2 of a check
    d0 = ndone;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    @(negedge clock) reset_n = 1'b0;
    #1;
    chk("midrst_out", {28'b0, avm_read, busy, id_ok, ts_ok}, 32'd0);
    chk("midrst_id", id_value, 32'd0);
    repeat (4) @(negedge clock);
    chk("midrst_ndone", ndone - d0, 32'd0);
    reset_n = 1'b1;
    dn_auto = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      dn_auto[c] = done;
    end
    chk("rearm_done", {24'b0, dn_auto}, 32'h20);
    chk("rearm_ok", {30'b0, id_ok, ts_ok}, 32'd3);

    // Persistently bad ID
    id_ret = 32'h1111_1110;
    r0 = nreads; d0 = ndone; wait_cyc = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    while (!done && wait_cyc < 60) begin
      @(negedge clock);
      wait_cyc++;
    end
    chk("badid_timeout", {31'b0, wait_cyc < 60}, 32'd1);
    repeat (4) @(negedge clock);
`ifdef SYSID_CHECK_RETRY_EN
    chk("badid_nreads", nreads - r0, 32'd8);
`else
    chk("badid_nreads", nreads - r0, 32'd2);
`endif
    chk("badid_ndone", ndone - d0, 32'd1);
    chk("badid_ok", {30'b0, id_ok, ts_ok}, 32'd1);
    chk("badid_id", id_value, 32'h1111_1110);
    chk("badid_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
